// File: rtl/dmem_lsu_pkg.sv
// Shared memory-map constants and load/store unit types.
// Used by the data-memory LSU and its alignment datapath.
package dmem_lsu_pkg;

  localparam logic [31:0] IMEM_BYTES = 32'h0000_4000;
  localparam logic [31:0] MEM_BYTES  = 32'h0001_0000;

  localparam logic [1:0] LS_SINGLE   = 2'b00;
  localparam logic [1:0] LS_HALFWORD = 2'b01;
  localparam logic [1:0] LS_WORD     = 2'b10;
  localparam logic       L_UNSIGNED  = 1'b1;

  localparam int ERR_ENUMS_WIDTH = 2;

  typedef enum logic [ERR_ENUMS_WIDTH-1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10
  } e_lsu_err;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } e_lsu_state;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and replicated store data,
// plus shift and sign/zero extension of returned load data.
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  n_bytes,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] sh_s;
  logic        zext_s;

  // Lane select and load-data extension by access size
  always_comb begin
    sh_s      = rdata >> {off, 3'b000};
    zext_s    = (is_unsigned == L_UNSIGNED);
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = sh_s;
    case (n_bytes)
      LS_SINGLE: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = zext_s ? {24'h00_0000, sh_s[7:0]} : {{24{sh_s[7]}}, sh_s[7:0]};
      end
      LS_HALFWORD: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = zext_s ? {16'h0000, sh_s[15:0]} : {{16{sh_s[15]}}, sh_s[15:0]};
      end
      // words only reach memory with off==0, so sh_s equals rdata here
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = sh_s;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between execute and the data-memory port: one request at a
// time, alignment/range checking, registered memory access and response.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] DMEM_BASE  = IMEM_BYTES,
  parameter logic [ADDR_WIDTH-1:0] DMEM_LIMIT = MEM_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_n_bytes,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  e_lsu_state state_r, state_n;
  e_lsu_err   err_s;
  logic       we_r, uns_r, uns_s;
  logic [1:0] size_r, off_r, size_s, off_s;
  logic       misalign_s, range_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_rep_s, rdata_ext_s;

  // Request checks; misalignment outranks out-of-range
  always_comb begin
    if (req_n_bytes >= LS_WORD) begin
      misalign_s = (req_addr[1:0] != 2'b00);
    end else if (req_n_bytes == LS_HALFWORD) begin
      misalign_s = req_addr[0];
    end else begin
      misalign_s = 1'b0;
    end
    range_s = (req_addr < DMEM_BASE) || (req_addr >= DMEM_LIMIT);
    if (misalign_s) begin
      err_s = ERR_MISALIGN;
    end else if (range_s) begin
      err_s = ERR_RANGE;
    end else begin
      err_s = ERR_NONE;
    end
  end

  // Aligner sees live request fields in IDLE, latched fields afterwards
  always_comb begin
    if (state_r == ST_IDLE) begin
      size_s = req_n_bytes;
      off_s  = req_addr[1:0];
      uns_s  = req_unsigned;
    end else begin
      size_s = size_r;
      off_s  = off_r;
      uns_s  = uns_r;
    end
  end

  lsu_align u_align (
    .n_bytes     (size_s),
    .off         (off_s),
    .is_unsigned (uns_s),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .be          (be_s),
    .wdata_rep   (wdata_rep_s),
    .rdata_ext   (rdata_ext_s)
  );

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_n = (err_s != ERR_NONE) ? ST_RESP : ST_ISSUE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_gnt) begin
          state_n = we_r ? ST_RESP : ST_WAIT;
        end else begin
          state_n = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_n = ST_RESP;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State register and latched request attributes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      size_r  <= 2'b00;
      off_r   <= 2'b00;
    end else begin
      state_r <= state_n;
      if ((state_r == ST_IDLE) && req_valid) begin
        we_r   <= req_we;
        uns_r  <= req_unsigned;
        size_r <= req_n_bytes;
        off_r  <= req_addr[1:0];
      end
    end
  end

  // Registered handshake, memory and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= '0;
    end else begin
      req_ready  <= (state_n == ST_IDLE);
      resp_valid <= (state_n == ST_RESP);
      if (state_n == ST_ISSUE) begin
        // loaded once on entry, then held stable until the grant
        if (state_r == ST_IDLE) begin
          mem_req   <= 1'b1;
          mem_we    <= req_we;
          mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_be    <= be_s;
          mem_wdata <= wdata_rep_s;
        end
      end else begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_be    <= 4'b0000;
        mem_wdata <= '0;
      end
      if (state_n == ST_RESP) begin
        case (state_r)
          ST_IDLE: begin
            resp_err   <= err_s;
            resp_rdata <= '0;
          end
          ST_WAIT: begin
            resp_err   <= ERR_NONE;
            resp_rdata <= rdata_ext_s;
          end
          default: begin
            resp_err   <= ERR_NONE;
            resp_rdata <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed, table-driven bench for dmem_lsu plus stall and reset sequences.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_n_bytes;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_n_bytes(req_n_bytes), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  nb;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] rrdata;
  } vec_t;

  vec_t vecs[16];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, " req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({nm, " resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({nm, " mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({nm, " mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({nm, " mem_addr"}, mem_addr, 32'd0);
    chk({nm, " mem_be"}, {28'd0, mem_be}, 32'd0);
    chk({nm, " mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // One transaction with immediate grant and read data one cycle later
  task automatic run_vec(input string nm, input vec_t v);
    logic [31:0] waddr;
    waddr = {v.addr[31:2], 2'b00};
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_n_bytes = v.nb;
    req_unsigned = v.uns; req_wdata = v.wdata;
    tick();
    req_valid = 1'b0;
    if (v.err != 2'b00) begin
      chk({nm, " err resp_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({nm, " err code"}, {30'd0, resp_err}, {30'd0, v.err});
      chk({nm, " err rdata"}, resp_rdata, 32'd0);
      chk({nm, " err mem_req"}, {31'd0, mem_req}, 32'd0);
    end else begin
      chk({nm, " issue mem_req"}, {31'd0, mem_req}, 32'd1);
      chk({nm, " issue mem_we"}, {31'd0, mem_we}, {31'd0, v.we});
      chk({nm, " issue mem_addr"}, mem_addr, waddr);
      chk({nm, " issue mem_be"}, {28'd0, mem_be}, {28'd0, v.be});
      if (v.we) chk({nm, " issue mem_wdata"}, mem_wdata, v.mwdata);
      chk({nm, " issue resp_valid"}, {31'd0, resp_valid}, 32'd0);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk({nm, " post-gnt mem_req"}, {31'd0, mem_req}, 32'd0);
      if (!v.we) begin
        chk({nm, " wait resp_valid"}, {31'd0, resp_valid}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = v.rdata;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
      end
      chk({nm, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({nm, " resp_err"}, {30'd0, resp_err}, 32'd0);
      chk({nm, " resp_rdata"}, resp_rdata, v.rrdata);
    end
    tick();
    chk({nm, " back resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({nm, " back req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    //          we    addr          nb     uns   wdata         rdata         err    be       mwdata        rrdata
    vecs[0]  = '{1'b1, 32'h0000_4005, 2'b00, 1'b0, 32'h0000_00AB, 32'h0,        2'b00, 4'b0010, 32'hABAB_ABAB, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_4006, 2'b01, 1'b0, 32'h0,        32'h8001_1234, 2'b00, 4'b1100, 32'h0,        32'hFFFF_8001};
    vecs[2]  = '{1'b0, 32'h0000_4006, 2'b01, 1'b1, 32'h0,        32'h8001_1234, 2'b00, 4'b1100, 32'h0,        32'h0000_8001};
    vecs[3]  = '{1'b0, 32'h0000_4002, 2'b10, 1'b0, 32'h0,        32'h0,        2'b01, 4'b0000, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 32'h0000_3FFC, 2'b10, 1'b0, 32'h0,        32'h0,        2'b10, 4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 32'h0001_0000, 2'b00, 1'b0, 32'h0000_00AB, 32'h0,        2'b10, 4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0003, 2'b01, 1'b0, 32'h0,        32'h0,        2'b01, 4'b0000, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 32'h0000_4007, 2'b00, 1'b0, 32'h0,        32'h8001_1234, 2'b00, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[8]  = '{1'b0, 32'h0000_4001, 2'b00, 1'b1, 32'h0,        32'h8001_1234, 2'b00, 4'b0010, 32'h0,        32'h0000_0012};
    vecs[9]  = '{1'b1, 32'h0000_FFFE, 2'b01, 1'b0, 32'h1234_ABCD, 32'h0,        2'b00, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_FFFC, 2'b11, 1'b0, 32'h0,        32'hDEAD_BEEF, 2'b00, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 32'h0000_4000, 2'b10, 1'b1, 32'hCAFE_F00D, 32'h0,        2'b00, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_4010, 2'b10, 1'b1, 32'h0,        32'h8000_0000, 2'b00, 4'b1111, 32'h0,        32'h8000_0000};
    vecs[13] = '{1'b0, 32'h0000_FFFF, 2'b00, 1'b0, 32'h0,        32'hA500_0000, 2'b00, 4'b1000, 32'h0,        32'hFFFF_FFA5};
    vecs[14] = '{1'b0, 32'h0000_3FFF, 2'b00, 1'b1, 32'h0,        32'h0,        2'b10, 4'b0000, 32'h0,        32'h0};
    vecs[15] = '{1'b0, 32'h0000_4003, 2'b01, 1'b1, 32'h0,        32'h0,        2'b01, 4'b0000, 32'h0,        32'h0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_n_bytes = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    check_idle_outputs("reset");
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset resp_err", {30'd0, resp_err}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Grant stall of 3 cycles, then read data 2 cycles after the grant;
    // a competing request is held on req_valid during the stall
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_4002; req_n_bytes = 2'b01;
    req_unsigned = 1'b0; req_wdata = 32'h5555_5555;
    tick();
    req_we = 1'b1; req_addr = 32'h0000_4008; req_n_bytes = 2'b10;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall%0d mem_req", c), {31'd0, mem_req}, 32'd1);
      chk($sformatf("stall%0d mem_addr", c), mem_addr, 32'h0000_4000);
      chk($sformatf("stall%0d mem_be", c), {28'd0, mem_be}, 32'h0000_000C);
      chk($sformatf("stall%0d mem_we", c), {31'd0, mem_we}, 32'd0);
      chk($sformatf("stall%0d req_ready", c), {31'd0, req_ready}, 32'd0);
      tick();
    end
    chk("stall gnt mem_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    req_valid = 1'b0;
    chk("stall wait1 ready", {31'd0, req_ready}, 32'd0);
    chk("stall wait1 resp_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    chk("stall wait2 ready", {31'd0, req_ready}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h7FFF_0000;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("stall resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("stall resp_rdata", resp_rdata, 32'h0000_7FFF);
    chk("stall resp ready", {31'd0, req_ready}, 32'd0);
    tick();
    chk("stall one-cycle pulse", {31'd0, resp_valid}, 32'd0);
    chk("stall resp_rdata hold", resp_rdata, 32'h0000_7FFF);

    // Reset while waiting for read data, then a stray rvalid
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_4020; req_n_bytes = 2'b10; req_unsigned = 1'b0;
    tick();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("rstwait");
    chk("rstwait resp_rdata", resp_rdata, 32'd0);
    chk("rstwait resp_err", {30'd0, resp_err}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    chk("stray rvalid resp_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    chk("stray rvalid later", {31'd0, resp_valid}, 32'd0);
    check_idle_outputs("after stray");
    run_vec("post-reset", vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit between the RV32I execute stage and the data-memory port. Accepts one load/store request at a time, checks alignment and data-memory range, and generates a word-aligned memory access with byte enables and replicated write data. For loads, it extracts, aligns and sign/zero-extends the returned data. Sits directly upstream of the data memory (DMEM region `0x0000_4000`–`0x0000_FFFF`) and downstream of the execute stage.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width.
- `DATA_WIDTH`, 32, word width; fixed at 32 (4 byte lanes).
- `DMEM_BASE`, `32'h0000_4000`, first legal data byte address.
- `DMEM_LIMIT`, `32'h0001_0000`, first illegal address above DMEM.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  execute stage presents a request.
- `req_ready`  out  1  LSU can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_n_bytes`  in  2  size: `2'b00` byte, `2'b01` halfword, `2'b1x` word.
- `req_unsigned`  in  1  zero-extend load (LBU/LHU); ignored for stores and words.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  2  `00` ok, `01` misaligned, `10` out of range.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  32  word address, `[1:0]` = 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated write data.
- `mem_gnt`  in  1  memory accepts `mem_req` this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read word.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready=1`. On `req_valid`, latch all request fields and offset `off=addr[1:0]`, then evaluate errors.
  - Misaligned: half with `off[0]=1`, or word with `off!=0`.
  - Out of range: `addr<DMEM_BASE` or `addr>=DMEM_LIMIT`.
  - Misaligned takes priority over out of range.
  - On error: go to RESP with the error code, with no memory access. Otherwise go to ISSUE.
- ISSUE: hold `mem_req=1` with stable `mem_*` until `mem_gnt`.
  - Store + gnt: go to RESP.
  - Load + gnt: go to WAIT.
  - Load + gnt + `mem_rvalid` in the same cycle: not allowed by the memory protocol; `mem_rvalid` is ignored outside WAIT.
- WAIT: on `mem_rvalid`, capture and extend `mem_rdata`, then go to RESP.
- RESP: `resp_valid=1` for exactly one cycle, then go to IDLE.
- Byte enables: byte `4'b0001<<off`; half `4'b0011<<off`; word `4'b1111`.
- Write data: byte `{4{wdata[7:0]}}`; half `{2{wdata[15:0]}}`; word `wdata`.
- `mem_addr = {addr[31:2],2'b00}`.
- Load extract: `sh = mem_rdata >> (8*off)`.
  - Byte: bit 7 sign-extended, or zero-extended if `req_unsigned`.
  - Half: bit 15 sign-extended, or zero-extended if `req_unsigned`.
  - Word: `mem_rdata` unchanged.

## Timing
- Reset values: state IDLE; `req_ready=1`; `resp_valid=0`; `resp_rdata=0`; `resp_err=0`; `mem_req=0`; `mem_we=0`; `mem_addr=0`; `mem_be=0`; `mem_wdata=0`.
- `mem_*` outputs are registered, and are zero whenever not in ISSUE.
- Request accepted at edge T (`req_valid && req_ready`):
  - ISSUE occupies cycle T+1.
  - Store with immediate gnt: `resp_valid` in cycle T+2.
  - Load with gnt at T+1 and rvalid at T+2: `resp_valid` in cycle T+3.
  - Error: `resp_valid` in cycle T+1.
- Each gnt stall or rvalid stall cycle adds 1 cycle of latency.
- Throughput: at most one request per 3 cycles (error path: 2 cycles).
- `resp_rdata`/`resp_err` are valid only while `resp_valid`; they hold their value otherwise.
- Reset in any state: next cycle is IDLE with reset outputs.
  - An in-flight `mem_req` is dropped.
  - A late `mem_rvalid` after reset is ignored.
- `req_valid` while not in IDLE: not accepted, because `req_ready=0`.

## Structure
- Add the following to the shared memory package:
  - `LS_SINGLE`, `LS_HALFWORD`, `LS_WORD`, `L_UNSIGNED`.
  - An `e_lsu_err` enum {`ERR_NONE=2'b00`, `ERR_MISALIGN=2'b01`, `ERR_RANGE=2'b10`} sized by `ERR_ENUMS_WIDTH`.
  - An `e_lsu_state` enum.
- `DMEM_BASE`/`DMEM_LIMIT` default from the package constants (`IMEM_BYTES`, `MEM_BYTES`).
- One combinational sub-module, `lsu_align`: inputs are size, offset, unsigned flag, wdata and rdata; outputs are be, replicated wdata and extended rdata. The FSM lives in `dmem_lsu`.

## Test plan
- Store byte, addr `0x4005`, wdata `0x000000AB`, gnt immediate:
  - ISSUE drives `mem_addr=0x4004`, `mem_be=0010`, `mem_wdata=0xABABABAB`.
  - `resp_valid` at T+2 with `err=00`.
- Load half signed and unsigned, addr `0x4006`, `mem_rdata=0x8001_1234`:
  - Signed: `resp_rdata=0xFFFF8001`.
  - Unsigned: `resp_rdata=0x00008001`.
  - Both respond at T+3.
- Word load at `0x4002`:
  - `resp_err=01` at T+1, `mem_req` never asserted.
- Word load at `0x3FFC`: `err=10`.
- Byte store at `0x1_0000`: `err=10`.
- Half load at `0x0003`: `err=01` (misaligned has priority over out of range).
- Stall: `mem_gnt` low 3 cycles, then `mem_rvalid` 2 cycles after gnt:
  - `mem_*` stable throughout ISSUE.
  - `req_ready=0` throughout.
  - `resp_valid` exactly one cycle.
- Reset asserted in WAIT, followed by a stray `mem_rvalid`:
  - All outputs at reset values.
  - No `resp_valid`.
  - Next request completes normally.
